// File: rtl/snake_pkg.sv
// Shared types and constants for the snake pixel generator: directions,
// FSM states, grid cell coordinates and the colour palette.
package snake_pkg;

  localparam int DEF_CELL_LOG2   = 4;
  localparam int DEF_GRID_W      = 40;
  localparam int DEF_GRID_H      = 30;
  localparam int DEF_SNAKE_LEN   = 8;
  localparam int DEF_MOVE_FRAMES = 8;

  // Coordinate widths cover the default 40x30 grid.
  localparam int X_W = 6;
  localparam int Y_W = 5;

  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  localparam logic [11:0] COL_OFF  = 12'h000;
  localparam logic [11:0] COL_HEAD = 12'hFF0;
  localparam logic [11:0] COL_BODY = 12'h0F0;
  localparam logic [11:0] COL_DEAD = 12'hF00;
  localparam logic [11:0] COL_BG   = 12'h002;

  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_body.sv
// Segment store for the snake: next-head/collision evaluation, the one-cycle
// shift on a move, and a registered head/body hit test for the queried pixel.
module snake_body
  import snake_pkg::*;
#(
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H,
  parameter int SNAKE_LEN = DEF_SNAKE_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  dir_e       step_dir,
  input  logic [9:0] query_x,
  input  logic [9:0] query_y,
  output logic       hit_head,
  output logic       hit_body,
  output logic       collide
);

  localparam logic [X_W:0] X_ONE  = (X_W+1)'(1);
  localparam logic [Y_W:0] Y_ONE  = (Y_W+1)'(1);
  localparam logic [X_W:0] X_LIM  = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(GRID_H);

  cell_t [SNAKE_LEN-1:0] seg;
  cell_t                 new_head;
  logic  [X_W:0]         nx;
  logic  [Y_W:0]         ny;
  logic                  wall_hit, self_hit;
  logic  [9:0]           qcx, qcy;
  logic                  q_in_grid, head_match, body_match;

  function automatic cell_t start_cell(input int i);
    cell_t c;
    c.x = X_W'(GRID_W / 2 - i);
    c.y = Y_W'(GRID_H / 2);
    return c;
  endfunction

  // One extra bit lets 0-1 wrap to a large value, so both walls are a single >= test.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first; a path that leaves a variable unassigned infers a latch.
    nx = {1'b0, seg[0].x};
    ny = {1'b0, seg[0].y};
    case (step_dir)
      DIR_RIGHT: nx = nx + X_ONE;
      DIR_LEFT:  nx = nx - X_ONE;
      DIR_DOWN:  ny = ny + Y_ONE;
      default:   ny = ny - Y_ONE;
    endcase
    new_head.x = nx[X_W-1:0];
    new_head.y = ny[Y_W-1:0];
    wall_hit   = (nx >= X_LIM) || (ny >= Y_LIM);
    self_hit   = 1'b0;
    // The tail is left out: it vacates the cell on this same move.
    for (int i = 0; i < SNAKE_LEN - 1; i++) begin
      if (seg[i] == new_head) self_hit = 1'b1;
    end
    collide = wall_hit || self_hit;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking '<='. The segment registers are
    // reset (unlike a plain data store) because the start snake is their
    // architectural initial value.
    if (rst || load) begin
      for (int i = 0; i < SNAKE_LEN; i++) seg[i] <= start_cell(i);
    end else if (step && !collide) begin
      seg <= {seg[SNAKE_LEN-2:0], new_head};
    end
  end

  assign qcx       = query_x >> CELL_LOG2;
  assign qcy       = query_y >> CELL_LOG2;
  assign q_in_grid = (qcx < 10'(GRID_W)) && (qcy < 10'(GRID_H));

  always_comb begin
    head_match = q_in_grid && (qcx == 10'(seg[0].x)) && (qcy == 10'(seg[0].y));
    body_match = 1'b0;
    for (int i = 1; i < SNAKE_LEN; i++) begin
      if (q_in_grid && (qcx == 10'(seg[i].x)) && (qcy == 10'(seg[i].y))) body_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_head <= 1'b0;
      hit_body <= 1'b0;
    end else begin
      hit_head <= head_match;
      hit_body <= body_match;
    end
  end

endmodule

// File: rtl/snake_renderer.sv
// Snake game pixel generator: FSM, direction latch and frame counter around
// the segment store, producing one-cycle-latency 12-bit rgb for the display.
module snake_renderer
  import snake_pkg::*;
#(
  parameter int CELL_LOG2   = DEF_CELL_LOG2,
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int SNAKE_LEN   = DEF_SNAKE_LEN,
  parameter int MOVE_FRAMES = DEF_MOVE_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic [3:0]  dir_req,
  input  logic        start,
  output logic [11:0] rgb,
  output logic        dead
);

  localparam logic [7:0] LAST_FRAME = 8'(MOVE_FRAMES - 1);

  state_e     state;
  dir_e       dir, pending, req_dir;
  logic [7:0] frame_cnt;
  logic       req_valid, req_ok, move_now, load, collide;
  logic       hit_head, hit_body, vis_q;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    case (dir_req)
      4'b0001: req_dir = DIR_RIGHT;
      4'b0010: req_dir = DIR_LEFT;
      4'b0100: req_dir = DIR_DOWN;
      4'b1000: req_dir = DIR_UP;
      default: req_valid = 1'b0;
    endcase
  end

  assign req_ok   = req_valid && (req_dir != opposite(dir));
  assign move_now = (state == RUN) && frame_tick && (frame_cnt == LAST_FRAME);
  assign load     = (state == DEAD) && start;

  snake_body #(
    .CELL_LOG2 (CELL_LOG2),
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H),
    .SNAKE_LEN (SNAKE_LEN)
  ) u_body (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (move_now),
    .step_dir (pending),
    .query_x  (pix_x),
    .query_y  (pix_y),
    .hit_head (hit_head),
    .hit_body (hit_body),
    .collide  (collide)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      frame_cnt <= '0;
      dead      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            pending <= req_dir;
            state   <= RUN;
          end
        end
        RUN: begin
          // The move consumes the old pending; a request this cycle lands on the next move.
          if (req_ok) pending <= req_dir;
          if (frame_tick) begin
            if (move_now) begin
              frame_cnt <= '0;
              dir       <= pending;
              if (collide) begin
                state <= DEAD;
                dead  <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        DEAD: begin
          if (start) begin
            state     <= IDLE;
            dir       <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
            frame_cnt <= '0;
            dead      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vis_q <= 1'b0;
    else     vis_q <= video_on;
  end

  // rgb decodes only flops, so it follows pix_x/pix_y by exactly one clk.
  always_comb begin
    rgb = COL_OFF;
    if (vis_q) begin
      if (hit_head)      rgb = COL_HEAD;
      else if (hit_body) rgb = dead ? COL_DEAD : COL_BODY;
      else               rgb = COL_BG;
    end
  end

endmodule

// File: tb/tb_snake_renderer.sv
// Self-checking bench for snake_renderer: directed scenarios plus random
// traffic, all compared every cycle against a queue-based game model.
module tb_snake_renderer;

  localparam int CELL_LOG2   = 4;
  localparam int GRID_W      = 40;
  localparam int GRID_H      = 30;
  localparam int SNAKE_LEN   = 8;
  localparam int MOVE_FRAMES = 8;

  logic        clk = 1'b0;
  logic        rst, video_on, frame_tick, start;
  logic [9:0]  pix_x, pix_y;
  logic [3:0]  dir_req;
  logic [11:0] rgb;
  logic        dead;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_RUN, M_DEAD} mstate_e;
  mstate_e m_state;
  int m_dx, m_dy, m_pdx, m_pdy, m_fc;
  int sx[$];
  int sy[$];

  always #5 clk = ~clk;

  snake_renderer #(
    .CELL_LOG2   (CELL_LOG2),
    .GRID_W      (GRID_W),
    .GRID_H      (GRID_H),
    .SNAKE_LEN   (SNAKE_LEN),
    .MOVE_FRAMES (MOVE_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .dir_req    (dir_req),
    .start      (start),
    .rgb        (rgb),
    .dead       (dead)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_state = M_IDLE;
    m_dx = 1; m_dy = 0; m_pdx = 1; m_pdy = 0; m_fc = 0;
    sx.delete(); sy.delete();
    for (int i = 0; i < SNAKE_LEN; i++) begin
      sx.push_back(GRID_W / 2 - i);
      sy.push_back(GRID_H / 2);
    end
  endfunction

  function automatic void model_hits(input int px, input int py, output bit h, output bit b);
    h = 0; b = 0;
    if (px < 640 && py < 480) begin
      for (int i = 0; i < SNAKE_LEN; i++) begin
        if (sx[i] == px / 16 && sy[i] == py / 16) begin
          if (i == 0) h = 1; else b = 1;
        end
      end
    end
  endfunction

  function automatic void model_step(input bit tk, input logic [3:0] req, input bit st);
    int rdx, rdy, nx, ny;
    bit rv, die;
    rdx = req[0] ? 1 : (req[1] ? -1 : 0);
    rdy = req[2] ? 1 : (req[3] ? -1 : 0);
    rv  = ($countones(req) == 1) && !(rdx == -m_dx && rdy == -m_dy);
    case (m_state)
      M_IDLE: if (rv) begin m_pdx = rdx; m_pdy = rdy; m_state = M_RUN; end
      M_RUN: begin
        if (tk) begin
          if (m_fc == MOVE_FRAMES - 1) begin
            m_fc = 0; m_dx = m_pdx; m_dy = m_pdy;
            nx = sx[0] + m_dx; ny = sy[0] + m_dy;
            die = nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H;
            for (int i = 0; i < SNAKE_LEN - 1; i++)
              if (sx[i] == nx && sy[i] == ny) die = 1;
            if (die) m_state = M_DEAD;
            else begin
              sx.push_front(nx); sy.push_front(ny);
              void'(sx.pop_back()); void'(sy.pop_back());
            end
          end else m_fc++;
        end
        if (rv) begin m_pdx = rdx; m_pdy = rdy; end
      end
      default: if (st) model_reset();
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit tk, input logic [3:0] req, input bit st, input bit rs,
                      input logic [9:0] px, input logic [9:0] py, input bit von);
    bit h, b;
    logic [11:0] exp_rgb;
    @(negedge clk);
    frame_tick = tk; dir_req = req; start = st; rst = rs;
    pix_x = px; pix_y = py; video_on = von;
    model_hits(int'(px), int'(py), h, b);
    if (rs) model_reset(); else model_step(tk, req, st);
    if (rs || !von) exp_rgb = 12'h000;
    else if (h)     exp_rgb = 12'hFF0;
    else if (b)     exp_rgb = (m_state == M_DEAD) ? 12'hF00 : 12'h0F0;
    else            exp_rgb = 12'h002;
    @(posedge clk);
    #1;
    check("rgb_model", 32'(rgb), 32'(exp_rgb));
    check("dead_model", 32'(dead), 32'(m_state == M_DEAD));
  endtask

  task automatic rand_pix(output logic [9:0] px, output logic [9:0] py);
    int k;
    if ($urandom_range(1, 0) == 1) begin
      k  = int'($urandom_range(SNAKE_LEN - 1, 0));
      px = 10'(sx[k] * 16 + int'($urandom_range(15, 0)));
      py = 10'(sy[k] * 16 + int'($urandom_range(15, 0)));
    end else begin
      px = 10'($urandom_range(719, 0));
      py = 10'($urandom_range(524, 0));
    end
  endtask

  task automatic tick_step(input bit tk, input logic [3:0] req, input bit st);
    logic [9:0] px, py;
    rand_pix(px, py);
    step(tk, req, st, 1'b0, px, py, $urandom_range(9, 0) != 0);
  endtask

  task automatic move_once();
    for (int k = 0; k < MOVE_FRAMES; k++) begin
      tick_step(1'b1, 4'b0000, 1'b0);
      tick_step(1'b0, 4'b0000, 1'b0);
    end
  endtask

  task automatic probe(input string tag, input int px, input int py, input bit von,
                       input logic [11:0] exp);
    step(1'b0, 4'b0000, 1'b0, 1'b0, 10'(px), 10'(py), von);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic do_reset();
    step(1'b0, 4'b0000, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1);
    check("reset_rgb", 32'(rgb), 32'h000);
    check("reset_dead", 32'(dead), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] px, py;
    logic [3:0] req;
    int r;
    rst = 1'b1; frame_tick = 1'b0; dir_req = 4'b0; start = 1'b0;
    pix_x = '0; pix_y = '0; video_on = 1'b0;
    model_reset();
    do_reset();

    // Reset snake rendering
    probe("t1_head", 320, 240, 1'b1, 12'hFF0);
    probe("t1_bg",     0,   0, 1'b1, 12'h002);
    probe("t1_off",  320, 240, 1'b0, 12'h000);
    probe("t1_body", 304, 240, 1'b1, 12'h0F0);

    // Start moving right, one move
    tick_step(1'b0, 4'b0001, 1'b0);
    move_once();
    probe("t2_head", 336, 240, 1'b1, 12'hFF0);
    probe("t2_tail", 224, 240, 1'b1, 12'h0F0);
    probe("t2_gone", 208, 240, 1'b1, 12'h002);

    // Reversal and multi-bit requests are ignored
    tick_step(1'b0, 4'b0010, 1'b0);
    tick_step(1'b0, 4'b0101, 1'b0);
    move_once();
    probe("t3_head", 352, 240, 1'b1, 12'hFF0);
    probe("t3_neck", 336, 240, 1'b1, 12'h0F0);

    // Right wall
    do_reset();
    tick_step(1'b0, 4'b0001, 1'b0);
    repeat (19) move_once();
    probe("t4_edge_head", 624, 240, 1'b1, 12'hFF0);
    check("t4_alive", 32'(dead), 32'd0);
    move_once();
    check("t4_dead", 32'(dead), 32'd1);
    probe("t4_head_stays", 624, 240, 1'b1, 12'hFF0);
    probe("t4_body_red",   608, 240, 1'b1, 12'hF00);
    probe("t4_offscreen",  640, 240, 1'b1, 12'h002);

    // Self collision: UP, LEFT, DOWN into segment 3
    do_reset();
    tick_step(1'b0, 4'b1000, 1'b0); move_once();
    tick_step(1'b0, 4'b0010, 1'b0); move_once();
    tick_step(1'b0, 4'b0100, 1'b0); move_once();
    check("t5_dead", 32'(dead), 32'd1);
    probe("t5_seg3_red", 304, 240, 1'b1, 12'hF00);
    probe("t5_head",     304, 224, 1'b1, 12'hFF0);

    // Restart from DEAD, start ignored in RUN, reset on a move tick
    tick_step(1'b0, 4'b0000, 1'b1);
    check("t6_dead_clr", 32'(dead), 32'd0);
    probe("t6_head", 320, 240, 1'b1, 12'hFF0);
    probe("t6_body", 304, 240, 1'b1, 12'h0F0);
    tick_step(1'b0, 4'b0001, 1'b0);
    tick_step(1'b0, 4'b0000, 1'b1);
    move_once();
    probe("t6_run_start_ign", 336, 240, 1'b1, 12'hFF0);
    repeat (MOVE_FRAMES - 1) begin
      tick_step(1'b1, 4'b0000, 1'b0);
      tick_step(1'b0, 4'b0000, 1'b0);
    end
    step(1'b1, 4'b0000, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1);
    probe("t6_rst_head", 320, 240, 1'b1, 12'hFF0);
    tick_step(1'b0, 4'b0001, 1'b0);
    repeat (MOVE_FRAMES - 1) begin
      tick_step(1'b1, 4'b0000, 1'b0);
      tick_step(1'b0, 4'b0000, 1'b0);
    end
    probe("t6_fc_cleared", 320, 240, 1'b1, 12'hFF0);
    tick_step(1'b1, 4'b0000, 1'b0);
    probe("t6_first_move", 336, 240, 1'b1, 12'hFF0);

    // Left wall via unsigned wrap at x=0
    do_reset();
    tick_step(1'b0, 4'b1000, 1'b0); move_once();
    tick_step(1'b0, 4'b0010, 1'b0);
    repeat (20) move_once();
    probe("t7_x0_head", 0, 224, 1'b1, 12'hFF0);
    check("t7_alive", 32'(dead), 32'd0);
    move_once();
    check("t7_dead", 32'(dead), 32'd1);
    probe("t7_head_stays", 0, 224, 1'b1, 12'hFF0);

    // Random traffic against the model
    do_reset();
    repeat (2500) begin
      r = int'($urandom_range(9, 0));
      if (r < 6)      req = 4'b0000;
      else if (r < 9) req = 4'b0001 << $urandom_range(3, 0);
      else            req = 4'($urandom_range(15, 0));
      rand_pix(px, py);
      step($urandom_range(2, 0) == 0, req, $urandom_range(19, 0) == 0,
           $urandom_range(599, 0) == 0, px, py, $urandom_range(9, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
